// File: rtl/module_validation_platform_v3.sv
// AXI4-Lite register bank with per-register read-only status inputs.
// Independent write (AW/W/B) and read (AR/R) state machines share one register array.
module module_validation_platform_v3 #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS = 8,
  parameter int ADDR_WIDTH = 12,
  parameter logic [NUM_REGS-1:0] RO_MASK = '0
) (
  input  logic                             ACLK,
  input  logic                             ARESET,
  input  logic [ADDR_WIDTH-1:0]            S_AXI_AWADDR,
  input  logic [2:0]                       S_AXI_AWPROT,
  input  logic                             S_AXI_AWVALID,
  output logic                             S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]            S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0]          S_AXI_WSTRB,
  input  logic                             S_AXI_WVALID,
  output logic                             S_AXI_WREADY,
  output logic [1:0]                       S_AXI_BRESP,
  output logic                             S_AXI_BVALID,
  input  logic                             S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]            S_AXI_ARADDR,
  input  logic [2:0]                       S_AXI_ARPROT,
  input  logic                             S_AXI_ARVALID,
  output logic                             S_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]            S_AXI_RDATA,
  output logic [1:0]                       S_AXI_RRESP,
  output logic                             S_AXI_RVALID,
  input  logic                             S_AXI_RREADY,
  output logic [NUM_REGS*DATA_WIDTH-1:0]   reg_out,
  input  logic [NUM_REGS*DATA_WIDTH-1:0]   reg_in,
  output logic [NUM_REGS-1:0]              wr_pulse
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFFS   = $clog2(STRB_W);
  localparam int IDXW   = $clog2(NUM_REGS);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} wState_e;
  typedef enum logic {R_IDLE, R_DATA} rState_e;

  wState_e                 wState_q;
  logic                    awReady_q, wReady_q, awHeld_q, wHeld_q;
  logic [ADDR_WIDTH-1:0]   awAddr_q;
  logic [DATA_WIDTH-1:0]   wData_q;
  logic [STRB_W-1:0]       wStrb_q;
  logic                    bValid_q;
  logic [1:0]              bResp_q;
  logic [NUM_REGS-1:0]     wrPulse_q, wrPulse_d;
  logic [DATA_WIDTH-1:0]   regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0]   regs_d [NUM_REGS];

  rState_e                 rState_q;
  logic                    arReady_q, rValid_q;
  logic [DATA_WIDTH-1:0]   rData_q;
  logic [1:0]              rResp_q;

  logic                    awHs, wHs, awHave, wHave, commit;
  logic [ADDR_WIDTH-1:0]   wAddrEff;
  logic [DATA_WIDTH-1:0]   wDataEff;
  logic [STRB_W-1:0]       wStrbEff;
  logic [IDXW-1:0]         wIdx, rIdx;
  logic                    wInRange, wWritable, rInRange, arHs;
  logic [DATA_WIDTH-1:0]   rDataSel;
  logic                    unusedBits;

  // A handshake arriving this cycle is used directly so the commit lands on the same edge.
  assign awHs      = S_AXI_AWVALID & awReady_q;
  assign wHs       = S_AXI_WVALID & wReady_q;
  assign awHave    = awHeld_q | awHs;
  assign wHave     = wHeld_q | wHs;
  assign commit    = (wState_q == W_IDLE) & awHave & wHave;
  assign wAddrEff  = awHs ? S_AXI_AWADDR : awAddr_q;
  assign wDataEff  = wHs ? S_AXI_WDATA : wData_q;
  assign wStrbEff  = wHs ? S_AXI_WSTRB : wStrb_q;
  assign wIdx      = wAddrEff[OFFS +: IDXW];
  assign wInRange  = (wAddrEff >> (OFFS + IDXW)) == '0;
  assign wWritable = wInRange & ~RO_MASK[wIdx];

  always_comb begin
    regs_d    = regs_q;
    wrPulse_d = '0;
    if (commit && wWritable) begin
      wrPulse_d[wIdx] = 1'b1;
      for (int b = 0; b < STRB_W; b++) begin
        if (wStrbEff[b]) regs_d[wIdx][b*8 +: 8] = wDataEff[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wState_q  <= W_IDLE;
      awReady_q <= 1'b0;
      wReady_q  <= 1'b0;
      awHeld_q  <= 1'b0;
      wHeld_q   <= 1'b0;
      awAddr_q  <= '0;
      wData_q   <= '0;
      wStrb_q   <= '0;
      bValid_q  <= 1'b0;
      bResp_q   <= RESP_OKAY;
      wrPulse_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      regs_q    <= regs_d;
      wrPulse_q <= wrPulse_d;
      case (wState_q)
        W_IDLE: begin
          if (commit) begin
            wState_q  <= W_RESP;
            awHeld_q  <= 1'b0;
            wHeld_q   <= 1'b0;
            awReady_q <= 1'b0;
            wReady_q  <= 1'b0;
            bValid_q  <= 1'b1;
            bResp_q   <= wInRange ? RESP_OKAY : RESP_SLVERR;
          end else begin
            if (awHs) begin
              awAddr_q <= S_AXI_AWADDR;
              awHeld_q <= 1'b1;
            end
            if (wHs) begin
              wData_q <= S_AXI_WDATA;
              wStrb_q <= S_AXI_WSTRB;
              wHeld_q <= 1'b1;
            end
            awReady_q <= ~awHave;
            wReady_q  <= ~wHave;
          end
        end
        W_RESP: begin
          if (S_AXI_BREADY) begin
            bValid_q  <= 1'b0;
            wState_q  <= W_IDLE;
            awReady_q <= 1'b1;
            wReady_q  <= 1'b1;
          end
        end
        default: wState_q <= W_IDLE;
      endcase
    end
  end

  // Read-only registers return the live status input rather than storage.
  assign arHs     = S_AXI_ARVALID & arReady_q;
  assign rIdx     = S_AXI_ARADDR[OFFS +: IDXW];
  assign rInRange = (S_AXI_ARADDR >> (OFFS + IDXW)) == '0;
  assign rDataSel = !rInRange ? '0 :
                    RO_MASK[rIdx] ? reg_in[int'(rIdx)*DATA_WIDTH +: DATA_WIDTH] : regs_q[rIdx];

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      rState_q  <= R_IDLE;
      arReady_q <= 1'b0;
      rValid_q  <= 1'b0;
      rData_q   <= '0;
      rResp_q   <= RESP_OKAY;
    end else begin
      case (rState_q)
        R_IDLE: begin
          if (arHs) begin
            rData_q   <= rDataSel;
            rResp_q   <= rInRange ? RESP_OKAY : RESP_SLVERR;
            rValid_q  <= 1'b1;
            arReady_q <= 1'b0;
            rState_q  <= R_DATA;
          end else begin
            arReady_q <= 1'b1;
          end
        end
        R_DATA: begin
          if (S_AXI_RREADY) begin
            rValid_q  <= 1'b0;
            arReady_q <= 1'b1;
            rState_q  <= R_IDLE;
          end
        end
        default: rState_q <= R_IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : gRegOut
    assign reg_out[i*DATA_WIDTH +: DATA_WIDTH] = RO_MASK[i] ? '0 : regs_q[i];
  end

  assign S_AXI_AWREADY = awReady_q;
  assign S_AXI_WREADY  = wReady_q;
  assign S_AXI_BVALID  = bValid_q;
  assign S_AXI_BRESP   = bResp_q;
  assign S_AXI_ARREADY = arReady_q;
  assign S_AXI_RVALID  = rValid_q;
  assign S_AXI_RDATA   = rData_q;
  assign S_AXI_RRESP   = rResp_q;
  assign wr_pulse      = wrPulse_q;

  assign unusedBits = ^{S_AXI_AWPROT, S_AXI_ARPROT, wAddrEff[OFFS-1:0], S_AXI_ARADDR[OFFS-1:0]};

endmodule

// File: tb/tb_module_validation_platform_v3.sv
// Self-checking bench: table-driven AXI-Lite transactions with a response scoreboard,
// followed by directed multi-cycle sequences (early W, stalls, same-edge access, reset).
`timescale 1ns/1ps
module tb_module_validation_platform_v3;
  localparam int DW = 32;
  localparam int NR = 8;
  localparam int AW = 12;
  localparam logic [NR-1:0] RO = 8'h80;

  logic ACLK = 1'b0;
  logic ARESET;
  logic [AW-1:0] S_AXI_AWADDR, S_AXI_ARADDR;
  logic [2:0] S_AXI_AWPROT, S_AXI_ARPROT;
  logic S_AXI_AWVALID, S_AXI_AWREADY, S_AXI_WVALID, S_AXI_WREADY;
  logic [DW-1:0] S_AXI_WDATA, S_AXI_RDATA;
  logic [DW/8-1:0] S_AXI_WSTRB;
  logic [1:0] S_AXI_BRESP, S_AXI_RRESP;
  logic S_AXI_BVALID, S_AXI_BREADY, S_AXI_ARVALID, S_AXI_ARREADY, S_AXI_RVALID, S_AXI_RREADY;
  logic [NR*DW-1:0] reg_out, reg_in;
  logic [NR-1:0] wr_pulse;

  always #5 ACLK = ~ACLK;

  module_validation_platform_v3 #(
    .DATA_WIDTH(DW), .NUM_REGS(NR), .ADDR_WIDTH(AW), .RO_MASK(RO)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .reg_out(reg_out), .reg_in(reg_in), .wr_pulse(wr_pulse)
  );

  typedef struct {
    logic        isWrite;
    logic [11:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  expResp;
    logic [31:0] expData;
  } vec_t;

  typedef struct {
    logic        isRead;
    logic [1:0]  resp;
    logic [31:0] data;
    string       name;
  } exp_t;

  int total = 0;
  int bad = 0;
  int pulseCount [NR];
  int expPulse [NR];
  logic [31:0] modelRegs [NR];
  exp_t expQ [$];
  vec_t vecs [$];

  // Each write strobe seen while out of reset counts once per cycle it is high.
  always @(negedge ACLK) begin
    if (!ARESET) begin
      for (int i = 0; i < NR; i++) if (wr_pulse[i]) pulseCount[i] = pulseCount[i] + 1;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeoutFail(input string name);
    total++;
    bad++;
    $display("[TB] FAIL %s: timed out waiting for handshake", name);
  endtask

  task automatic checkOutput(input logic isRead, input logic [1:0] resp, input logic [31:0] data);
    exp_t e;
    if (expQ.size() == 0) begin
      timeoutFail("scoreboard underflow");
      return;
    end
    e = expQ.pop_front();
    check({e.name, " kind"}, {63'd0, isRead}, {63'd0, e.isRead});
    check({e.name, " resp"}, {62'd0, resp}, {62'd0, e.resp});
    if (e.isRead) check({e.name, " data"}, {32'd0, data}, {32'd0, e.data});
  endtask

  task automatic applyStimulus(input vec_t v, input string name);
    exp_t e;
    int n;
    logic awFire, wFire;
    logic [2:0] idx;
    e.isRead = ~v.isWrite;
    e.resp = v.expResp;
    e.data = v.expData;
    e.name = name;
    expQ.push_back(e);
    idx = v.addr[4:2];
    if (v.isWrite) begin
      if (v.addr[11:5] == 7'd0 && !RO[idx]) begin
        expPulse[idx]++;
        for (int b = 0; b < 4; b++) if (v.strb[b]) modelRegs[idx][b*8 +: 8] = v.data[b*8 +: 8];
      end
      S_AXI_AWADDR = v.addr;
      S_AXI_WDATA = v.data;
      S_AXI_WSTRB = v.strb;
      S_AXI_AWVALID = 1'b1;
      S_AXI_WVALID = 1'b1;
      n = 0;
      while ((S_AXI_AWVALID || S_AXI_WVALID) && n < 20) begin
        awFire = S_AXI_AWVALID & S_AXI_AWREADY;
        wFire = S_AXI_WVALID & S_AXI_WREADY;
        @(negedge ACLK);
        n++;
        if (awFire) S_AXI_AWVALID = 1'b0;
        if (wFire) S_AXI_WVALID = 1'b0;
      end
      if (S_AXI_AWVALID || S_AXI_WVALID) begin
        timeoutFail({name, " aw/w"});
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID = 1'b0;
      end
      n = 0;
      while (!S_AXI_BVALID && n < 20) begin
        @(negedge ACLK);
        n++;
      end
      if (S_AXI_BVALID) begin
        checkOutput(1'b0, S_AXI_BRESP, 32'h0);
        S_AXI_BREADY = 1'b1;
        @(negedge ACLK);
        S_AXI_BREADY = 1'b0;
      end else begin
        timeoutFail({name, " bvalid"});
        void'(expQ.pop_front());
      end
    end else begin
      S_AXI_ARADDR = v.addr;
      S_AXI_ARVALID = 1'b1;
      n = 0;
      while (S_AXI_ARVALID && n < 20) begin
        awFire = S_AXI_ARREADY;
        @(negedge ACLK);
        n++;
        if (awFire) S_AXI_ARVALID = 1'b0;
      end
      if (S_AXI_ARVALID) begin
        timeoutFail({name, " ar"});
        S_AXI_ARVALID = 1'b0;
      end
      n = 0;
      while (!S_AXI_RVALID && n < 20) begin
        @(negedge ACLK);
        n++;
      end
      if (S_AXI_RVALID) begin
        checkOutput(1'b1, S_AXI_RRESP, S_AXI_RDATA);
        S_AXI_RREADY = 1'b1;
        @(negedge ACLK);
        S_AXI_RREADY = 1'b0;
      end else begin
        timeoutFail({name, " rvalid"});
        void'(expQ.pop_front());
      end
    end
  endtask

  initial begin
    ARESET = 1'b1;
    S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0;
    S_AXI_ARADDR = '0; S_AXI_ARPROT = '0; S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0;
    for (int i = 0; i < NR; i++) begin
      reg_in[i*DW +: DW] = 32'h1111_0000 + i;
      modelRegs[i] = '0;
      pulseCount[i] = 0;
      expPulse[i] = 0;
    end
    reg_in[7*DW +: DW] = 32'hCAFE_0001;

    // write/read vectors; out-of-range at 0x100, read-only at 0x1C
    vecs.push_back('{1'b1, 12'h000, 32'h1, 4'hF, 2'b00, 32'h0});
    vecs.push_back('{1'b1, 12'h004, 32'h2, 4'hF, 2'b00, 32'h0});
    vecs.push_back('{1'b1, 12'h008, 32'h3, 4'hF, 2'b00, 32'h0});
    vecs.push_back('{1'b1, 12'h00C, 32'h4, 4'hF, 2'b00, 32'h0});
    vecs.push_back('{1'b0, 12'h000, 32'h0, 4'h0, 2'b00, 32'h1});
    vecs.push_back('{1'b0, 12'h004, 32'h0, 4'h0, 2'b00, 32'h2});
    vecs.push_back('{1'b0, 12'h008, 32'h0, 4'h0, 2'b00, 32'h3});
    vecs.push_back('{1'b0, 12'h00C, 32'h0, 4'h0, 2'b00, 32'h4});
    vecs.push_back('{1'b1, 12'h004, 32'hFFFF_FFFF, 4'hF, 2'b00, 32'h0});
    vecs.push_back('{1'b1, 12'h004, 32'h0000_0000, 4'b0101, 2'b00, 32'h0});
    vecs.push_back('{1'b0, 12'h004, 32'h0, 4'h0, 2'b00, 32'hFF00_FF00});
    vecs.push_back('{1'b0, 12'h007, 32'h0, 4'h0, 2'b00, 32'hFF00_FF00});
    vecs.push_back('{1'b1, 12'h01C, 32'h1234, 4'hF, 2'b00, 32'h0});
    vecs.push_back('{1'b0, 12'h01C, 32'h0, 4'h0, 2'b00, 32'hCAFE_0001});
    vecs.push_back('{1'b1, 12'h100, 32'hBAD0_BAD0, 4'hF, 2'b10, 32'h0});
    vecs.push_back('{1'b0, 12'h100, 32'h0, 4'h0, 2'b10, 32'h0});
    vecs.push_back('{1'b0, 12'h000, 32'h0, 4'h0, 2'b00, 32'h1});
    vecs.push_back('{1'b1, 12'h008, 32'h55, 4'h0, 2'b00, 32'h0});
    vecs.push_back('{1'b0, 12'h008, 32'h0, 4'h0, 2'b00, 32'h3});

    repeat (3) @(negedge ACLK);
    check("reset awready", {63'd0, S_AXI_AWREADY}, 64'd0);
    check("reset wready", {63'd0, S_AXI_WREADY}, 64'd0);
    check("reset arready", {63'd0, S_AXI_ARREADY}, 64'd0);
    check("reset bvalid/rvalid", {62'd0, S_AXI_BVALID, S_AXI_RVALID}, 64'd0);
    check("reset resp/rdata", {30'd0, S_AXI_BRESP, S_AXI_RRESP, S_AXI_RDATA}, 64'd0);
    check("reset wr_pulse", {56'd0, wr_pulse}, 64'd0);
    check("reset reg_out any", {63'd0, |reg_out}, 64'd0);

    ARESET = 1'b0;
    @(negedge ACLK);
    check("post-reset readies", {61'd0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 64'd7);

    for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i], $sformatf("vec%0d", i));

    for (int i = 0; i < NR; i++) begin
      check($sformatf("pulse count r%0d", i), 64'(pulseCount[i]), 64'(expPulse[i]));
      check($sformatf("reg_out r%0d", i), {32'd0, reg_out[i*DW +: DW]}, {32'd0, modelRegs[i]});
    end

    // W arrives three cycles before AW; the commit must follow the AW handshake
    S_AXI_WDATA = 32'hDEAD_BEEF; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
    @(negedge ACLK);
    S_AXI_WVALID = 1'b0;
    check("early W wready drop", {63'd0, S_AXI_WREADY}, 64'd0);
    repeat (2) @(negedge ACLK);
    check("early W no bvalid", {63'd0, S_AXI_BVALID}, 64'd0);
    check("early W awready", {63'd0, S_AXI_AWREADY}, 64'd1);
    S_AXI_AWADDR = 12'h008; S_AXI_AWVALID = 1'b1;
    @(negedge ACLK);
    S_AXI_AWVALID = 1'b0;
    check("late AW bvalid/bresp", {61'd0, S_AXI_BVALID, S_AXI_BRESP}, 64'h4);
    check("late AW wr_pulse", {56'd0, wr_pulse}, 64'h04);
    check("late AW reg2", {32'd0, reg_out[2*DW +: DW]}, 64'hDEAD_BEEF);
    S_AXI_BREADY = 1'b1;
    @(negedge ACLK);
    S_AXI_BREADY = 1'b0;
    check("late AW pulse one cycle", {56'd0, wr_pulse}, 64'd0);

    // Response stalls on both channels at once
    S_AXI_AWADDR = 12'h00C; S_AXI_WDATA = 32'hA5A5_A5A5; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    @(negedge ACLK);
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    S_AXI_ARADDR = 12'h004; S_AXI_ARVALID = 1'b1;
    @(negedge ACLK);
    S_AXI_ARVALID = 1'b0;
    check("stall arready low", {63'd0, S_AXI_ARREADY}, 64'd0);
    for (int c = 0; c < 5; c++) begin
      check($sformatf("stall B c%0d", c), {61'd0, S_AXI_BVALID, S_AXI_BRESP}, 64'h4);
      check($sformatf("stall R c%0d", c), {29'd0, S_AXI_RVALID, S_AXI_RRESP, S_AXI_RDATA},
            {29'd0, 1'b1, 2'b00, 32'hFF00_FF00});
      @(negedge ACLK);
    end
    S_AXI_BREADY = 1'b1; S_AXI_RREADY = 1'b1;
    @(negedge ACLK);
    S_AXI_BREADY = 1'b0; S_AXI_RREADY = 1'b0;
    check("stall release", {62'd0, S_AXI_BVALID, S_AXI_RVALID}, 64'd0);

    // Read and write of the same register on one edge returns the old value
    S_AXI_AWADDR = 12'h00C; S_AXI_WDATA = 32'h99; S_AXI_ARADDR = 12'h00C;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_ARVALID = 1'b1;
    @(negedge ACLK);
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
    check("same-edge valids", {62'd0, S_AXI_BVALID, S_AXI_RVALID}, 64'd3);
    check("same-edge old data", {32'd0, S_AXI_RDATA}, 64'hA5A5_A5A5);
    check("same-edge new reg3", {32'd0, reg_out[3*DW +: DW]}, 64'h99);
    S_AXI_BREADY = 1'b1; S_AXI_RREADY = 1'b1;
    @(negedge ACLK);
    S_AXI_BREADY = 1'b0; S_AXI_RREADY = 1'b0;

    // Reset while a write response is pending
    S_AXI_AWADDR = 12'h000; S_AXI_WDATA = 32'h77;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    @(negedge ACLK);
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    check("pre-reset bvalid", {63'd0, S_AXI_BVALID}, 64'd1);
    ARESET = 1'b1;
    @(negedge ACLK);
    check("reset in W_RESP bvalid", {63'd0, S_AXI_BVALID}, 64'd0);
    check("reset in W_RESP awready", {63'd0, S_AXI_AWREADY}, 64'd0);
    check("reset in W_RESP reg_out", {63'd0, |reg_out}, 64'd0);
    ARESET = 1'b0;
    @(negedge ACLK);
    check("re-reset readies", {61'd0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 64'd7);

    // A held W beat is discarded by reset and never pairs with a later AW
    S_AXI_WDATA = 32'h5A; S_AXI_WVALID = 1'b1;
    @(negedge ACLK);
    S_AXI_WVALID = 1'b0;
    ARESET = 1'b1;
    @(negedge ACLK);
    ARESET = 1'b0;
    @(negedge ACLK);
    S_AXI_AWADDR = 12'h000; S_AXI_AWVALID = 1'b1;
    @(negedge ACLK);
    S_AXI_AWVALID = 1'b0;
    repeat (3) @(negedge ACLK);
    check("abandoned W no bvalid", {63'd0, S_AXI_BVALID}, 64'd0);
    check("abandoned W reg0", {32'd0, reg_out[31:0]}, 64'd0);
    check("abandoned W wready", {62'd0, S_AXI_AWREADY, S_AXI_WREADY}, 64'd1);
    S_AXI_WDATA = 32'h66; S_AXI_WVALID = 1'b1;
    @(negedge ACLK);
    S_AXI_WVALID = 1'b0;
    check("fresh W commit bvalid", {63'd0, S_AXI_BVALID}, 64'd1);
    check("fresh W commit reg0", {32'd0, reg_out[31:0]}, 64'h66);
    S_AXI_BREADY = 1'b1;
    @(negedge ACLK);
    S_AXI_BREADY = 1'b0;
    repeat (2) @(negedge ACLK);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
